nb_lsu: RTL
===========

# nb_lsu

Non-blocking load/store unit for the multi-cycle RV32I cores; the parametrised successor to the single-outstanding stall-for-memory data path. It accepts up to MAX_OUTSTANDING in-order data-memory requests from the execute stage and tracks each one in a circular queue. It sign- or zero-extends load data and returns it through a writeback port with backpressure. It keeps a per-register pending scoreboard, so the core stalls only on true RAW/WAW hazards against in-flight loads.

## Interface
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; only 32 is supported, and any other value is an elaboration error.
- MAX_OUTSTANDING, 4, queue depth (allocated-but-not-retired requests); power of two, 1..16.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- issue_valid_i  in  1  execute stage presents a memory op.
- issue_ready_o  out  1  queue can accept; held 0 while rst_n is low.
- issue_is_load_i  in  1  1 = load, 0 = store.
- issue_addr_i  in  ADDR_WIDTH  byte address (ALU result).
- issue_wdata_i  in  DATA_WIDTH  store data, already lane-aligned.
- issue_wstrb_i  in  DATA_WIDTH/8  store byte strobes.
- issue_funct3_i  in  3  load width/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- issue_rd_i  in  5  load destination.
- rs1_i, rs2_i, rd_i  in  5 each  hazard query from the decode of the next instruction.
- hazard_o  out  1  the next instruction must stall.
- dmem_addr_o, dmem_wdata_o, dmem_wstrb_o  out  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  request fields.
- dmem_read_o, dmem_write_o  out  1  one-cycle request pulses.
- dmem_rdata_i  in  DATA_WIDTH  read data.
- dmem_ready_i  in  1  one completion per request, in request order.
- wb_valid_o  out  1  load result ready for the regfile.
- wb_rd_o  out  5  destination register.
- wb_data_o  out  DATA_WIDTH  extended load data.
- wb_ready_i  in  1  regfile write port granted.
- idle_o  out  1  queue empty (used for fence/halt).
- misalign_o  out  1  misaligned-access pulse; present only with the macro.

## Operation
- Queue entry fields: {is_load, rd, funct3, addr[1:0], data, done}.
- The queue has three pointers: alloc (tail), resp (oldest entry not yet done) and head. A count tracks occupancy.
- Issue handshake: issue_valid_i & issue_ready_o. issue_ready_o = (count < MAX_OUTSTANDING), taken from the registered count. An entry freed in a cycle cannot be reused in that same cycle.
- On accept:
  - allocate the entry at tail;
  - register the request outputs;
  - for a load with issue_rd_i != 0, set pending[issue_rd_i].
- dmem_ready_i marks the entry at resp done and advances resp.
  - For a load, it also latches dmem_rdata_i into the entry.
  - dmem_ready_i arriving with no undone entry is ignored.
- Head retire:
  - a done store retires immediately;
  - a done load drives wb_valid_o and retires on wb_valid_o & wb_ready_i, which also clears pending[rd].
  - A load with rd = 0 retires without asserting wb_valid_o.
- Load extraction, indexed by the entry's addr[1:0]:
  - LB/LBU select the byte at addr[1:0], then sign-/zero-extend.
  - LH/LHU select the half at addr[1], then extend.
  - LW passes the word through.
- hazard_o = any nonzero register among rs1_i, rs2_i, rd_i whose registered pending bit is set.
  - It is conservative: the bit clears the cycle after the wb handshake.
  - x0 never hazards.
- If the core issues despite hazard_o, the pending bit stays set until the later load retires. The bench treats such an issue as a protocol violation.

## Timing
- Reset values (rst_n low at a clk edge):
  - count, pointers, pending and done bits all cleared;
  - every output 0, except idle_o = 1.
- Reset mid-operation discards every entry. Completions for pre-reset requests then find no undone entry and are ignored.
- Issue accepted at cycle T → dmem_read_o/dmem_write_o high for exactly cycle T+1, with the address/data fields valid in that same cycle. Fields are 0 whenever no pulse is driven.
- The memory may assert dmem_ready_i no earlier than T+2.
- dmem_ready_i at cycle R → earliest wb_valid_o at R+1 if the entry is at the head.
- wb_valid_o, wb_rd_o and wb_data_o hold stable until wb_ready_i is sampled high.
- Simultaneous events:
  - issue and retire in one cycle: count unchanged;
  - issue, completion and retire in one cycle: all applied;
  - completion while the head is stalled on wb_ready_i: stored in its own entry, no loss.
- Full: issue_ready_o = 0 when count = MAX_OUTSTANDING.
- Pointers wrap modulo MAX_OUTSTANDING.

## Configuration
- NB_LSU_MISALIGN_CHECK_EN defined:
  - a misaligned issue is accepted but not sent to memory and allocates no entry (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0);
  - misalign_o pulses high in cycle T+1.
- NB_LSU_MISALIGN_CHECK_EN undefined:
  - the port is absent and the address passes through unchanged;
  - the extraction byte offset still applies.

## Test plan
- LW x5 @0x100 with memory returning 0xDEADBEEF at latency 3 → dmem_read_o at T+1; wb_rd_o = 5 and wb_data_o = 0xDEADBEEF one cycle after ready; pending[5] set, then cleared.
- LB @0x103 and LBU @0x103 with rdata 0x80FF_FF7F → wb_data_o = 0xFFFF_FF80 and 0x0000_0080 respectively.
- Four back-to-back loads with MAX_OUTSTANDING = 4 and memory stalled → issue_ready_o drops after the fourth; one completion plus one wb handshake → ready returns the next cycle; results retire in issue order.
- Load x7 in flight; query rs1 = 7 → hazard_o = 1; rs2 = 0 with rd = 0 → hazard_o = 0; hazard_o clears the cycle after x7's wb handshake.
- wb_ready_i held low for 5 cycles while two completions arrive → wb outputs stable, both data values preserved; a store issued behind them retires only after both loads.
- Reset asserted with 3 entries outstanding, then a stale dmem_ready_i → idle_o = 1, no wb_valid_o, hazard_o = 0. With the macro defined, SW @0x102 → misalign_o at T+1, no dmem_write_o.

Source files
------------

// File: rtl/nb_lsu.sv
// Non-blocking load/store unit: in-order circular request queue, load extension and a
// per-register pending scoreboard. Define NB_LSU_MISALIGN_CHECK_EN to trap misaligned accesses.
module nb_lsu #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic                    issue_is_load_i,
  input  logic [ADDR_WIDTH-1:0]   issue_addr_i,
  input  logic [DATA_WIDTH-1:0]   issue_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] issue_wstrb_i,
  input  logic [2:0]              issue_funct3_i,
  input  logic [4:0]              issue_rd_i,
  input  logic [4:0]              rs1_i,
  input  logic [4:0]              rs2_i,
  input  logic [4:0]              rd_i,
  output logic                    hazard_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] dmem_wstrb_o,
  output logic                    dmem_read_o,
  output logic                    dmem_write_o,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
  input  logic                    dmem_ready_i,
  output logic                    wb_valid_o,
  output logic [4:0]              wb_rd_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic                    wb_ready_i,
`ifdef NB_LSU_MISALIGN_CHECK_EN
  output logic                    misalign_o,
`endif
  output logic                    idle_o
);

  localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("nb_lsu: DATA_WIDTH must be 32");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16 ||
      (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $error("nb_lsu: MAX_OUTSTANDING must be a power of two in 1..16");
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Queue state
  logic [CntW-1:0]            count_q, count_d;
  logic [CntW-1:0]            inflight_q, inflight_d;
  logic [PtrW-1:0]            alloc_ptr_q, alloc_ptr_d;
  logic [PtrW-1:0]            resp_ptr_q, resp_ptr_d;
  logic [PtrW-1:0]            head_ptr_q, head_ptr_d;
  logic [31:0]                pending_q, pending_d;
  logic [MAX_OUTSTANDING-1:0] done_q;
  logic [MAX_OUTSTANDING-1:0] is_load_q;
  logic [4:0]                 rd_q     [MAX_OUTSTANDING];
  logic [2:0]                 funct3_q [MAX_OUTSTANDING];
  logic [1:0]                 off_q    [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0]      data_q   [MAX_OUTSTANDING];

  // Registered request pulse and fields
  logic                  dmem_read_q, dmem_write_q;
  logic [ADDR_WIDTH-1:0] dmem_addr_q;
  logic [DATA_WIDTH-1:0] dmem_wdata_q;
  logic [StrbW-1:0]      dmem_wstrb_q;

  logic misaligned, accept, alloc, cpl, head_done, head_wb, retire;

  always_comb begin
    misaligned = 1'b0;
`ifdef NB_LSU_MISALIGN_CHECK_EN
    case (issue_funct3_i[1:0])
      2'b01:   misaligned = issue_addr_i[0];
      2'b10:   misaligned = (issue_addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
`endif
  end

  assign issue_ready_o = rst_n & (count_q < CntW'(MAX_OUTSTANDING));
  assign accept        = issue_valid_i & issue_ready_o;
  assign alloc         = accept & ~misaligned;
  // Completions with nothing outstanding (e.g. stale after reset) are dropped here.
  assign cpl           = dmem_ready_i & (inflight_q != '0);
  assign head_done     = (count_q != '0) & done_q[head_ptr_q];
  assign head_wb       = head_done & is_load_q[head_ptr_q] & (rd_q[head_ptr_q] != 5'd0);
  assign retire        = head_done & (~head_wb | wb_ready_i);

  always_comb begin
    count_d     = count_q + CntW'(alloc) - CntW'(retire);
    inflight_d  = inflight_q + CntW'(alloc) - CntW'(cpl);
    alloc_ptr_d = alloc  ? ptr_inc(alloc_ptr_q) : alloc_ptr_q;
    resp_ptr_d  = cpl    ? ptr_inc(resp_ptr_q)  : resp_ptr_q;
    head_ptr_d  = retire ? ptr_inc(head_ptr_q)  : head_ptr_q;
    pending_d   = pending_q;
    if (retire && head_wb) pending_d[rd_q[head_ptr_q]] = 1'b0;
    if (alloc && issue_is_load_i && issue_rd_i != 5'd0) pending_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      inflight_q  <= '0;
      alloc_ptr_q <= '0;
      resp_ptr_q  <= '0;
      head_ptr_q  <= '0;
      pending_q   <= '0;
    end else begin
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      alloc_ptr_q <= alloc_ptr_d;
      resp_ptr_q  <= resp_ptr_d;
      head_ptr_q  <= head_ptr_d;
      pending_q   <= pending_d;
    end
  end

  // Retire, completion and allocation always target distinct entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q    <= '0;
      is_load_q <= '0;
      rd_q      <= '{default: '0};
      funct3_q  <= '{default: '0};
      off_q     <= '{default: '0};
      data_q    <= '{default: '0};
    end else begin
      if (retire) done_q[head_ptr_q] <= 1'b0;
      if (cpl) begin
        done_q[resp_ptr_q] <= 1'b1;
        if (is_load_q[resp_ptr_q]) data_q[resp_ptr_q] <= dmem_rdata_i;
      end
      if (alloc) begin
        done_q[alloc_ptr_q]    <= 1'b0;
        is_load_q[alloc_ptr_q] <= issue_is_load_i;
        rd_q[alloc_ptr_q]      <= issue_rd_i;
        funct3_q[alloc_ptr_q]  <= issue_funct3_i;
        off_q[alloc_ptr_q]     <= issue_addr_i[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
    end else begin
      dmem_read_q  <= alloc & issue_is_load_i;
      dmem_write_q <= alloc & ~issue_is_load_i;
      dmem_addr_q  <= alloc ? issue_addr_i : '0;
      dmem_wdata_q <= (alloc & ~issue_is_load_i) ? issue_wdata_i : '0;
      dmem_wstrb_q <= (alloc & ~issue_is_load_i) ? issue_wstrb_i : '0;
    end
  end

`ifdef NB_LSU_MISALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= accept & misaligned;
  end
  assign misalign_o = misalign_q;
`endif

  assign dmem_read_o  = dmem_read_q;
  assign dmem_write_o = dmem_write_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign dmem_wstrb_o = dmem_wstrb_q;

  assign wb_valid_o = head_wb;
  assign wb_rd_o    = head_wb ? rd_q[head_ptr_q] : 5'd0;
  assign wb_data_o  = head_wb ? load_extract(funct3_q[head_ptr_q], off_q[head_ptr_q],
                                             data_q[head_ptr_q]) : '0;

  assign hazard_o = ((rs1_i != 5'd0) && pending_q[rs1_i]) ||
                    ((rs2_i != 5'd0) && pending_q[rs2_i]) ||
                    ((rd_i  != 5'd0) && pending_q[rd_i]);

  assign idle_o = (count_q == '0);

endmodule
